// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared defaults and rename-entry type for the renamed register file
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_TAG_W = 4;
    localparam int ZERO_REG  = 0;

    typedef struct packed {
        logic                 busy;
        logic [DEF_TAG_W-1:0] tag;
    } rename_entry_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// regfile_read_port : one read mux with x0 override; optional commit bypass
// (REGFILE_COMMIT_BYPASS_EN). Rev 1.0
// ============================================================================
`default_nettype none

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = 32,
    parameter int AW    = DEF_AW,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic [AW-1:0]                i_addr,
    input  logic [NREG-1:0][XLEN-1:0]    i_data,
    input  logic [NREG-1:0]              i_busy,
    input  logic [NREG-1:0][TAG_W-1:0]   i_tag,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic                         i_rdy,
    input  logic                         i_cmt_en,
    input  logic [AW-1:0]                i_cmt_addr,
    input  logic [TAG_W-1:0]             i_cmt_tag,
    input  logic [XLEN-1:0]              i_cmt_data,
`endif
    output logic [XLEN-1:0]              o_data,
    output logic                         o_busy,
    output logic [TAG_W-1:0]             o_tag
);

    logic [XLEN-1:0]  w_data;
    logic             w_busy;
    logic [TAG_W-1:0] w_tag;
    logic             w_is_zero;

    assign w_is_zero = (i_addr == AW'(ZERO_REG));

    always_comb begin
        w_data = i_data[i_addr];
        w_busy = i_busy[i_addr];
        w_tag  = i_tag[i_addr];
`ifdef REGFILE_COMMIT_BYPASS_EN
        // Data always forwards; busy only drops if this commit owns the rename.
        if (i_rdy && i_cmt_en && !w_is_zero && (i_cmt_addr == i_addr)) begin
            w_data = i_cmt_data;
            if (w_busy && (w_tag == i_cmt_tag)) begin
                w_busy = 1'b0;
            end
        end
`endif
        if (w_is_zero) begin
            w_data = '0;
            w_busy = 1'b0;
            w_tag  = '0;
        end
    end

    assign o_data = w_data;
    assign o_busy = w_busy;
    assign o_tag  = w_tag;

endmodule : regfile_read_port

`default_nettype wire

// File: rtl/renamed_reg_file.sv
// ============================================================================
// renamed_reg_file : architectural register file with busy/ROB-tag rename state,
// NRD read ports, one issue and one commit port. Optional REGFILE_COMMIT_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module renamed_reg_file
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = 32,
    parameter int AW    = DEF_AW,
    parameter int TAG_W = DEF_TAG_W,
    parameter int NRD   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic [TAG_W-1:0]      iss_tag,
    input  logic                  cmt_en,
    input  logic [AW-1:0]         cmt_addr,
    input  logic [TAG_W-1:0]      cmt_tag,
    input  logic [XLEN-1:0]       cmt_data,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [NREG-1:0][XLEN-1:0]  r_data;
    logic [NREG-1:0]            r_busy;
    logic [NREG-1:0][TAG_W-1:0] r_tag;
    logic [AW:0]                r_busy_cnt;

    logic                       w_cmt_wr;
    logic                       w_iss_wr;
    logic [NREG-1:0]            w_busy_nxt;
    logic [NREG-1:0][TAG_W-1:0] w_tag_nxt;
    logic [AW:0]                w_busy_cnt_nxt;

    assign w_cmt_wr = cmt_en && (cmt_addr != AW'(ZERO_REG));
    assign w_iss_wr = iss_en && (iss_addr != AW'(ZERO_REG)) && !flush;

    // Issue is applied after commit so a same-cycle rename always wins busy/tag.
    always_comb begin
        w_busy_nxt = r_busy;
        w_tag_nxt  = r_tag;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_cmt_wr && r_busy[cmt_addr] && (r_tag[cmt_addr] == cmt_tag)) begin
                w_busy_nxt[cmt_addr] = 1'b0;
            end
            if (w_iss_wr) begin
                w_busy_nxt[iss_addr] = 1'b1;
                w_tag_nxt[iss_addr]  = iss_tag;
            end
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_busy     <= '0;
            r_tag      <= '0;
            r_busy_cnt <= '0;
        end else if (rdy) begin
            if (w_cmt_wr) begin
                r_data[cmt_addr] <= cmt_data;
            end
            r_busy     <= w_busy_nxt;
            r_tag      <= w_tag_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd_port
            regfile_read_port #(
                .XLEN  (XLEN),
                .NREG  (NREG),
                .AW    (AW),
                .TAG_W (TAG_W)
            ) u_rd_port (
                .i_addr     (rd_addr[k*AW +: AW]),
                .i_data     (r_data),
                .i_busy     (r_busy),
                .i_tag      (r_tag),
`ifdef REGFILE_COMMIT_BYPASS_EN
                .i_rdy      (rdy),
                .i_cmt_en   (cmt_en),
                .i_cmt_addr (cmt_addr),
                .i_cmt_tag  (cmt_tag),
                .i_cmt_data (cmt_data),
`endif
                .o_data     (rd_data[k*XLEN +: XLEN]),
                .o_busy     (rd_busy[k]),
                .o_tag      (rd_tag[k*TAG_W +: TAG_W])
            );
        end
    endgenerate

endmodule : renamed_reg_file

`default_nettype wire

// File: doc/renamed_reg_file.md
Name: renamed_reg_file

Overview:
- Parametrised architectural register file with per-register rename state (busy bit plus ROB tag) for the out-of-order core.
- Supports N read ports, one issue (rename) port and one commit port.
- Commit clears the busy bit only when the committing tag matches the current rename tag. Flush clears all rename state.
- Sits between decode/issue (source lookup, destination rename) and the ROB commit stage.

Parameters:
- XLEN, 32, data width per register.
- NREG, 32, number of architectural registers; register 0 hardwired to zero.
- AW, 5, register address width (clog2 NREG).
- TAG_W, 4, ROB tag width.
- NRD, 2, number of read ports.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  committed register value per port.
- rd_busy  out  NRD  register has a pending rename.
- rd_tag  out  NRD*TAG_W  pending ROB tag; valid only when rd_busy is set.
- iss_en  in  1  rename destination this cycle.
- iss_addr  in  AW  destination register.
- iss_tag  in  TAG_W  ROB tag of the renaming instruction.
- cmt_en  in  1  ROB commits a register write.
- cmt_addr  in  AW  committed destination.
- cmt_tag  in  TAG_W  ROB tag of the committing entry.
- cmt_data  in  XLEN  committed value.
- flush  in  1  misprediction recovery.
- busy_cnt  out  AW+1  number of registers currently busy (registered).

Behaviour:
- Reset (async, rst=1): all data = 0, busy = 0, tags = 0, busy_cnt = 0. Applies immediately, including mid-operation; outputs read 0/not-busy.
- rdy=0: no state updates; reads remain combinational on held state.
- Reads: combinational from the state present before this edge.
  - Address 0 always returns data 0, busy 0, tag 0.
  - Same-cycle issue never affects reads, so a renaming instruction sees the old mapping of its own sources.
- Commit, at posedge when rdy & cmt_en & cmt_addr != 0:
  - data[cmt_addr] <= cmt_data, unconditionally.
  - busy[cmt_addr] cleared only if busy is set and tag[cmt_addr] == cmt_tag; otherwise a younger rename exists and busy/tag are kept.
- Issue, at posedge when rdy & iss_en & iss_addr != 0 & !flush: busy <= 1, tag <= iss_tag.
- Issue and commit to the same address in the same cycle:
  - Data is written.
  - Issue wins on busy/tag, even if the tags match.
- Flush: all busy cleared at posedge; tags left stale and ignored. A commit in the same cycle still writes its data. Issue is ignored.
- Writes to address 0 are discarded; register 0 never becomes busy.
- busy_cnt: registered population count of busy bits, updated on the same edge as those bits.
  - 0 after flush or reset.
  - Maximum NREG-1.
- Latency: a committed value or cleared busy bit is visible on reads the cycle after the commit edge, unless the optional bypass is enabled.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: a read port whose address equals cmt_addr (nonzero), with cmt_en & rdy and a stored tag equal to cmt_tag while busy, returns cmt_data with rd_busy=0 in the same cycle.
  - On a tag mismatch, the port returns stored busy/tag with data = cmt_data.
  - This is a combinational path from the commit inputs to the read outputs.
- Undefined: reads reflect registered state only; no commit-to-read combinational path.

Decomposition:
- Package regfile_pkg holds:
  - XLEN, AW, TAG_W defaults.
  - ZERO_REG constant (0).
  - A packed struct for the rename entry {busy, tag}.
- Sub-module regfile_read_port: one address mux with the x0 override and the optional bypass. Instantiated NRD times in a generate loop.

Test Plan:
- Reset then read x5 on both ports -> data 0, busy 0, busy_cnt 0. Assert rst asynchronously mid-run after writes -> outputs 0 before the next clk edge.
- Issue x3 tag 7; commit x3 tag 7 data 0xDEADBEEF -> next cycle x3 reads 0xDEADBEEF, busy 0; busy_cnt goes 1 then 0.
- Issue x3 tag 7, then issue x3 tag 9, then commit x3 tag 7 data 0x11 -> data 0x11, busy 1, tag 9.
- Same cycle: issue x4 tag 2 and commit x4 tag 2 data 0x55 -> data 0x55, busy 1, tag 2.
- Issue x1, x2, x6; flush with simultaneous commit x2 data 0xA5 and issue x8 -> all busy 0, x2 = 0xA5, x8 not busy, busy_cnt 0.
- Issue/commit to x0 with data 0xFFFF -> x0 reads 0, never busy. With REGFILE_COMMIT_BYPASS_EN: read x3 (busy, tag 7) during commit x3 tag 7 data 0x42 -> same-cycle data 0x42, busy 0.
